// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone bus bundle shared by the masters, the arbiter and the SDRAM slave.
interface wshb_if (input logic clk, input logic rst);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        stb;
    logic        cyc;
    logic        ack;
    modport master (input clk, rst, dat_sm, ack, output adr, dat_ms, sel, we, cti, bte, stb, cyc);
    modport slave  (input clk, rst, adr, dat_ms, sel, we, cti, bte, stb, cyc, output dat_sm, ack);
endinterface

// File: rtl/wshb_arbiter_rr_pick2.sv
// rr_pick2: one-hot round-robin pick between two requesters; a tie goes to the one that did not own last.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    always_comb o_gnt = &i_req ? (i_last ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: round-robin arbiter sharing one Wishbone slave between the VGA reader and the mire writer,
// with a stall watchdog that evicts an owner whose strobe goes unacknowledged.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    wshb_if.slave        wshb_ifs_vga,
    wshb_if.slave        wshb_ifs_mire,
    wshb_if.master       wshb_ifm,
    output logic [1:0]   grant,
    output logic         timeout
);
    arb_state_t       r_state, w_next;
    logic             r_last;
    logic [1:0]       r_blk;
    logic [CNT_W-1:0] r_cnt;
    logic             w_own0, w_own1, w_own_cyc, w_own_stb, w_to;
    logic [1:0]       w_req, w_pick;

    assign w_own0    = r_state == OWN0;
    assign w_own1    = r_state == OWN1;
    assign w_own_cyc = w_own0 ? wshb_ifs_vga.cyc : w_own1 & wshb_ifs_mire.cyc;
    assign w_own_stb = w_own0 ? wshb_ifs_vga.stb : w_own1 & wshb_ifs_mire.stb;
    assign w_req     = {wshb_ifs_mire.cyc & ~r_blk[1], wshb_ifs_vga.cyc & ~r_blk[0]};
    // An ack on the threshold cycle wins: the owner keeps the bus.
    assign w_to      = w_own_cyc & w_own_stb & ~wshb_ifm.ack & (r_cnt == CNT_W'(TIMEOUT - 1));

    rr_pick2 u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_blk   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_last  <= w_next == OWN0 ? 1'b0 : w_next == OWN1 ? 1'b1 : r_last;
            r_blk   <= {w_to & w_own1 | r_blk[1] & wshb_ifs_mire.cyc,
                        w_to & w_own0 | r_blk[0] & wshb_ifs_vga.cyc};
            r_cnt   <= (w_next != r_state || wshb_ifm.ack || !w_own_stb) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pick[0] ? OWN0 : w_pick[1] ? OWN1 : IDLE;
            OWN0:    if (!wshb_ifs_vga.cyc || w_to) w_next = w_req[1] ? OWN1 : IDLE;
            OWN1:    if (!wshb_ifs_mire.cyc || w_to) w_next = w_req[0] ? OWN0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Forwarding is muxed by the registered state only, so no path loops through cyc.
    always_comb begin
        grant                = r_state;
        timeout              = w_to;
        wshb_ifm.cyc         = w_own_cyc;
        wshb_ifm.stb         = w_own_stb;
        wshb_ifm.adr         = w_own1 ? wshb_ifs_mire.adr    : wshb_ifs_vga.adr;
        wshb_ifm.dat_ms      = w_own1 ? wshb_ifs_mire.dat_ms : wshb_ifs_vga.dat_ms;
        wshb_ifm.sel         = w_own1 ? wshb_ifs_mire.sel    : wshb_ifs_vga.sel;
        wshb_ifm.we          = w_own1 ? wshb_ifs_mire.we     : wshb_ifs_vga.we;
        wshb_ifm.cti         = w_own1 ? wshb_ifs_mire.cti    : wshb_ifs_vga.cti;
        wshb_ifm.bte         = w_own1 ? wshb_ifs_mire.bte    : wshb_ifs_vga.bte;
        wshb_ifs_vga.ack     = w_own0 & wshb_ifm.ack;
        wshb_ifs_mire.ack    = w_own1 & wshb_ifm.ack;
        wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;
        wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;
    end
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: random two-master traffic against an owner/last/blocked/stall-count model, checked through a scoreboard queue.
module tb_wshb_arbiter;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       timeout;

    wshb_if vga_if  (.clk(clk), .rst(rst));
    wshb_if mire_if (.clk(clk), .rst(rst));
    wshb_if m_if    (.clk(clk), .rst(rst));

    wshb_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .wshb_ifs_vga  (vga_if),
        .wshb_ifs_mire (mire_if),
        .wshb_ifm      (m_if),
        .grant         (grant),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  grant;
        logic        to;
        logic        cyc;
        logic        stb;
        logic [31:0] adr;
        logic        we;
        logic [1:0]  ack;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_to = 0;
    int   dut_to  = 0;

    int       owner = -1;
    int       last  = 1;
    int       stall = 0;
    bit [1:0] blk   = 2'b00;

    bit          cyc[2];
    bit          stb[2];
    bit          we[2];
    logic [31:0] adr[2];
    bit          sack;
    logic [31:0] sdat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (timeout === 1'b1) dut_to++;
            check("grant",    {30'd0, grant},       {30'd0, e.grant});
            check("timeout",  {31'd0, timeout},     {31'd0, e.to});
            check("m_cyc",    {31'd0, m_if.cyc},    {31'd0, e.cyc});
            check("m_stb",    {31'd0, m_if.stb},    {31'd0, e.stb});
            check("m_adr",    m_if.adr,             e.adr);
            check("m_we",     {31'd0, m_if.we},     {31'd0, e.we});
            check("vga_ack",  {31'd0, vga_if.ack},  {31'd0, e.ack[0]});
            check("mire_ack", {31'd0, mire_if.ack}, {31'd0, e.ack[1]});
            check("vga_dat",  vga_if.dat_sm,        e.dat);
            check("mire_dat", mire_if.dat_sm,       e.dat);
        end
    end

    task automatic step(input bit do_rst, input bit tie, input int ack_pct);
        exp_t     e;
        int       o, oi, n, nstall;
        bit       to_now;
        bit [1:0] req, nblk;
        @(negedge clk);
        rst = do_rst;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = tie ? 1'b1 : ($urandom_range(0, 15) == 0 ? !cyc[i] : cyc[i]);
            stb[i] = cyc[i] && ($urandom_range(0, 7) != 0);
            we[i]  = 1'($urandom_range(0, 1));
            adr[i] = $urandom;
        end
        sack = $urandom_range(0, 99) < ack_pct;
        sdat = $urandom;
        vga_if.cyc  = cyc[0]; vga_if.stb  = stb[0]; vga_if.we  = we[0]; vga_if.adr  = adr[0];
        mire_if.cyc = cyc[1]; mire_if.stb = stb[1]; mire_if.we = we[1]; mire_if.adr = adr[1];
        m_if.ack = sack;
        m_if.dat_sm = sdat;
        if (do_rst) begin
            owner = -1; last = 1; stall = 0; blk = 2'b00;
        end
        #1;
        o  = owner;
        oi = (o < 0) ? 0 : o;
        to_now  = o >= 0 && cyc[oi] && stb[oi] && !sack && (stall + 1 == TO);
        e.grant = o < 0 ? 2'b00 : (o == 0 ? 2'b01 : 2'b10);
        e.to    = to_now;
        e.cyc   = o >= 0 && cyc[oi];
        e.stb   = o >= 0 && stb[oi];
        e.adr   = o == 1 ? adr[1] : adr[0];
        e.we    = o == 1 ? we[1] : we[0];
        e.ack   = {o == 1 && sack, o == 0 && sack};
        e.dat   = sdat;
        q.push_back(e);
        if (to_now) model_to++;
        req = {cyc[1] && !blk[1], cyc[0] && !blk[0]};
        if (o < 0)
            n = (req[0] && req[1]) ? 1 - last : req[0] ? 0 : req[1] ? 1 : -1;
        else
            n = (!cyc[oi] || to_now) ? (req[1 - oi] ? 1 - oi : -1) : o;
        for (int i = 0; i < 2; i++)
            nblk[i] = (to_now && o == i) || (blk[i] && cyc[i]);
        nstall = (n != o || sack || !(o >= 0 && stb[oi])) ? 0 : stall + 1;
        @(posedge clk);
        if (!do_rst) begin
            owner = n;
            if (n >= 0) last = n;
            blk   = nblk;
            stall = nstall;
        end
    endtask

    initial begin
        int pcts[4];
        pcts = '{0, 30, 90, 100};
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0;
        end
        vga_if.cyc = 1'b0;  vga_if.stb = 1'b0;  vga_if.dat_ms = 32'h0000_0a0a;
        vga_if.sel = 4'hf;  vga_if.cti = 3'd0;  vga_if.bte = 2'd0;
        mire_if.cyc = 1'b0; mire_if.stb = 1'b0; mire_if.dat_ms = 32'h0000_b1b1;
        mire_if.sel = 4'h3; mire_if.cti = 3'd2; mire_if.bte = 2'd0;
        m_if.ack = 1'b0;    m_if.dat_sm = '0;
        repeat (2) step(1'b1, 1'b0, 50);
        step(1'b0, 1'b1, 50);
        step(1'b0, 1'b1, 50);
        for (int p = 0; p < 16; p++) begin
            repeat (150) step(1'b0, 1'b0, pcts[p % 4]);
            if (p % 4 == 3) begin
                step(1'b1, 1'b0, 100);
                step(1'b0, 1'b1, 100);
                step(1'b0, 1'b1, 100);
            end
        end
        repeat (2) @(negedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        check("timeout_count", dut_to, model_to);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wshb_arbiter.md
# wshb_arbiter

Two-master, one-slave Wishbone arbiter that shares the SDRAM port between the VGA frame reader (master 0) and the pattern/mire writer (master 1). It uses round-robin arbitration at Wishbone-cycle granularity and locks the grant while the owner holds `cyc`. A watchdog frees the bus if the slave stalls. It sits between the two `wshb_if` masters and the SDRAM controller, in the Wishbone clock domain.

## Interface
- `TIMEOUT`, default 1024: cycles of `stb` without `ack` before forced release; legal range 2..65535.
- `clk` input, 1 bit: Wishbone clock. Same net as `wshb_ifm.clk`.
- `rst` input, 1 bit: asynchronous, active-high reset. Same net as `wshb_ifm.rst`.
- `wshb_ifs_vga` `wshb_if.slave`: master 0 port (VGA reader).
- `wshb_ifs_mire` `wshb_if.slave`: master 1 port (mire writer).
- `wshb_ifm` `wshb_if.master`: to the SDRAM slave.
- `grant` output, 2 bits: one-hot owner; `01` = VGA, `10` = mire, `00` = idle.
- `timeout` output, 1 bit: one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, OWN0, OWN1. `last` register holds the most recent owner. `blk0` and `blk1` are per-master blocked flags.
- Request for master i: `req_i = cyc_i & ~blk_i`.
- **IDLE**
  - Only one master requesting: go to that OWN state.
  - Both requesting: grant the master not equal to `last`.
  - No request: stay in IDLE.
- **OWNi**
  - Granted master drops `cyc`: go to OWNj if `req_j`, else IDLE. The switch is direct, with no IDLE bubble.
  - Otherwise stay in OWNi.
- Entering OWNi sets `last <= i`.
- **Forwarding**
  - All fields of the owner are forwarded combinationally to `wshb_ifm`, muxed by the registered state: `adr`, `dat_ms`, `sel`, `we`, `cti`, `bte`, `stb`, `cyc`.
  - In IDLE, `wshb_ifm.cyc = 0` and `wshb_ifm.stb = 0`. Other fields come from master 0.
- **Return path**
  - `wshb_ifm.dat_sm` goes to both slaves.
  - `ack` goes to the owner only. A non-owner always sees `ack = 0`, even if it asserts `stb`.
- **Watchdog**
  - 16-bit counter, cleared on any `ack`, when the owner's `stb` is low, or on state change.
  - Increments while the owner has `stb = 1` and `ack = 0`.
  - On reaching `TIMEOUT - 1`:
    - pulse `timeout`;
    - set `blk_i` for the owner;
    - go to IDLE, or to OWNj if `req_j`.
- `blk_i` clears when master i's `cyc` is sampled low.
- **Reset**
  - State IDLE, `last = 1` (VGA wins the first tie).
  - `blk0 = blk1 = 0`, counter 0.
  - `grant = 00`, `timeout = 0`, `wshb_ifm.cyc = 0`, `wshb_ifm.stb = 0`.
  - Reset asserted mid-burst drops `cyc` to the slave immediately, because the path is combinational from state. Transactions in flight are lost.

## Timing
- Arbitration latency is 1 cycle from `cyc_i` sampled high in IDLE to the OWNi state. `stb` is forwarded in that same cycle.
- Handover: the owner drops `cyc` at edge n and the other master owns from edge n+1. The slave sees at least one cycle of `cyc = 0`, because the owner's own `cyc = 0` is forwarded.
- Forward path has zero latency and no added registers. The `ack` mux uses the registered state only, so there is no combinational loop through `cyc`.
- `grant` is registered and equals the state encoding.
- A burst of length N with `ack` every cycle never triggers the watchdog.
- If `ack` and the timeout threshold coincide, the `ack` wins: the counter clears and there is no release.
- Both `cyc` drop and threshold in the same cycle: this is a normal release, and `blk` is not set.

## Structure
- Package `wshb_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t`;
  - constant `CNT_W = 16`.
- One sub-module, `rr_pick2`: combinational round-robin pick from `req[1:0]` and `last`, output one-hot.
- The FSM, watchdog and muxes live in `wshb_arbiter`.

## Test plan
- VGA alone, `cyc` held for 64 acks -> `grant = 01` one cycle after `cyc`. Slave sees 64 strobes and addresses in sequence. Mire sees `ack = 0` throughout.
- Both raise `cyc` in the same cycle after reset -> VGA owns first. VGA drops `cyc` -> mire owns on the next edge. VGA re-requests -> VGA owns again after mire drops `cyc`.
- Mire owns, VGA waiting -> on mire `cyc` fall, `grant` goes `10` to `01` with no `00` cycle.
- Slave never acks, `TIMEOUT = 8` -> `timeout` pulses on the 8th `stb` cycle and `grant` returns to `00`. VGA stays blocked until it drops `cyc` for one cycle, then is granted again.
- `ack` arrives on the threshold cycle -> no `timeout` and the grant is kept.
- `rst` asserted mid-burst -> `wshb_ifm.cyc` and `stb` go 0 immediately and `grant = 00`. After release, VGA is granted on the first tie.
